// File: rtl/gray_pulse_gen.sv
// Gray-count decoder driving phase-locked pulse bursts timed in counter steps.
// Optional non-Gray step checker enabled by defining STEP_CHECK_EN.
`timescale 1ns/1ps
module gray_pulse_gen #(
    parameter int N       = 4,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       gray_in,
    input  logic               start,
    input  logic               stop,
    input  logic [N-1:0]       phase,
    input  logic [N-1:0]       width,
    input  logic [BURST_W-1:0] burst,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       bin_out,
    output logic               step_err
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH} state_t;

    state_t             state;
    logic [N-1:0]       gray_q;
    logic [N-1:0]       bin_dec;
    logic               step_stb;
    logic [N-1:0]       phase_r;
    logic [N-1:0]       width_r;
    logic [N-1:0]       step_cnt;
    logic [BURST_W-1:0] burst_r;
    logic [BURST_W-1:0] pulse_cnt;
    logic [BURST_W-1:0] pulse_cnt_inc;

    // Binary bit i is the XOR of all Gray bits from i upward.
    always_comb begin
        bin_dec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bin_dec[i] = ^(gray_q >> i);
        end
    end

    assign pulse_cnt_inc = pulse_cnt + BURST_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q   <= '0;
            bin_out  <= '0;
            step_stb <= 1'b0;
        end else begin
            gray_q   <= gray_in;
            bin_out  <= bin_dec;
            step_stb <= (bin_dec != bin_out);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase_r   <= '0;
            width_r   <= '0;
            burst_r   <= '0;
            step_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                pulse_out <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            phase_r   <= phase;
                            width_r   <= (width == '0) ? N'(1) : width;
                            burst_r   <= burst;
                            pulse_cnt <= '0;
                            state     <= ARM;
                            busy      <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (step_stb && (bin_out == phase_r)) begin
                            state     <= HIGH;
                            step_cnt  <= N'(1);
                            pulse_out <= 1'b1;
                        end
                    end
                    HIGH: begin
                        // step_cnt counts steps already spent high; leave once it reaches width_r
                        if (step_stb) begin
                            if (step_cnt == width_r) begin
                                pulse_cnt <= pulse_cnt_inc;
                                pulse_out <= 1'b0;
                                if ((burst_r != '0) && (pulse_cnt_inc == burst_r)) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ARM;
                                end
                            end else begin
                                step_cnt <= step_cnt + N'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STEP_CHECK_EN
    logic [N-1:0] gray_prev;
    logic [N-1:0] gray_diff;
    logic         multi_bit;
    logic         err_clr;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign gray_diff = gray_q ^ gray_prev;
    assign multi_bit = ((gray_diff & (gray_diff - N'(1))) != '0);
    assign err_clr   = (state == IDLE) && start && !stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_prev <= '0;
            step_err  <= 1'b0;
        end else begin
            gray_prev <= gray_q;
            if (multi_bit) begin
                step_err <= 1'b1;
            end else if (err_clr) begin
                step_err <= 1'b0;
            end
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_pulse_gen.sv
// Scoreboard bench for gray_pulse_gen: expected pulse edges / done strobes are queued
// with their cycle numbers; a negedge monitor pops and compares each observed event.
`timescale 1ns/1ps
module tb_gray_pulse_gen;
    localparam int N  = 4;
    localparam int BW = 8;
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;
`ifdef STEP_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  gray_in;
    logic          start;
    logic          stop;
    logic [N-1:0]  phase;
    logic [N-1:0]  width;
    logic [BW-1:0] burst;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic [N-1:0]  bin_out;
    logic          step_err;

    gray_pulse_gen #(.N(N), .BURST_W(BW)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .start(start), .stop(stop),
        .phase(phase), .width(width), .burst(burst), .pulse_out(pulse_out),
        .busy(busy), .done(done), .bin_out(bin_out), .step_err(step_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int kind; int at;} ev_t;
    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic prev_p = 1'b0;
    int   cur = 0;

    function automatic logic [N-1:0] b2g(int v);
        logic [N-1:0] b;
        b = v[N-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(int kind, int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: event kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                fails++;
                $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    // Monitor: every pulse edge and done strobe must match the head of the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (pulse_out !== prev_p) sb_pop((pulse_out === 1'b1) ? EV_RISE : EV_FALL);
            if (done !== 1'b0) sb_pop(EV_DONE);
        end
        prev_p = pulse_out;
    end

    task automatic sb_drain(string name);
        repeat (4) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic hold_at(int v);
        @(posedge clk); #1;
        cur     = v;
        gray_in = b2g(v);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One Gray step per clock; stop pulsed together with step index stop_i
    task automatic count(int n, int stop_i);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == stop_i + 1 && stop_i >= 0) begin
                check("stop_busy", busy, 0);
                check("stop_pulse", pulse_out, 0);
            end
            stop    = (i == stop_i);
            cur     = (cur + 1) % 16;
            gray_in = b2g(cur);
        end
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic do_start(int ph, int wd, int bu);
        @(posedge clk); #1;
        start = 1'b1;
        phase = ph[N-1:0];
        width = wd[N-1:0];
        burst = bu[BW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        phase = N'($urandom);
        width = N'($urandom);
        burst = BW'($urandom);
        check("start_busy", busy, 1);
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int k;

        // 1: reset with random inputs
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        gray_in = '0; phase = '0; width = '0; burst = '0;
        repeat (2) begin
            @(posedge clk); #1;
            start   = 1'($urandom);
            stop    = 1'($urandom);
            gray_in = N'($urandom);
            phase   = N'($urandom);
            width   = N'($urandom);
            burst   = BW'($urandom);
        end
        @(negedge clk);
        check("rst_pulse", pulse_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", step_err, 0);
        check("rst_bin", bin_out, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stop = 1'b0; gray_in = '0;
        mon_en = 1'b1;

        // 2: phase 3, width 2, burst 2 -> two pulses 16 clocks apart, done on second fall
        hold_at(0);
        do_start(3, 2, 2);
        t0 = cyc + 1;
        push(EV_RISE, t0 + 5);  push(EV_FALL, t0 + 7);
        push(EV_RISE, t0 + 21); push(EV_FALL, t0 + 23); push(EV_DONE, t0 + 23);
        count(24, -1);
        sb_drain("t2_drain");
        check("t2_busy_end", busy, 0);

        // 3: width 0 acts as 1, single pulse at phase 0
        hold_at(13);
        do_start(0, 0, 1);
        t0 = cyc + 1;
        push(EV_RISE, t0 + 5); push(EV_FALL, t0 + 6); push(EV_DONE, t0 + 6);
        count(8, -1);
        sb_drain("t3_drain");
        check("t3_busy_end", busy, 0);

        // 4: stop inside HIGH of a continuous run
        hold_at(0);
        do_start(2, 4, 0);
        t0 = cyc + 1;
        push(EV_RISE, t0 + 4); push(EV_FALL, t0 + 6);
        count(24, 5);
        sb_drain("t4_drain");
        check("t4_busy_end", busy, 0);

        // 5: multi-bit Gray jump 0001 -> 0110
        hold_at(1);
        do_start(9, 1, 1);
        pulse_stop();
        check("t5_err_pre", step_err, 0);
        @(posedge clk); #1;
        gray_in = 4'b0110;
        cur = 4;
        k = cyc;
        @(posedge clk); #1;
        check("t5_err_k1", step_err, 0);
        check("t5_bin_k1", bin_out, 1);
        @(posedge clk); #1;
        check("t5_err_k2", step_err, ERR_EXP);
        check("t5_bin_k2", bin_out, 4);
        check("t5_cycle", cyc - k, 2);
        repeat (5) @(posedge clk);
        #1;
        check("t5_err_sticky", step_err, ERR_EXP);
        do_start(9, 1, 1);
        check("t5_err_clr", step_err, 0);
        pulse_stop();
        check("t5_busy_end", busy, 0);

        // 6: continuous run of 300 pulses, then freeze inside HIGH, then resume
        hold_at(0);
        do_start(5, 3, 0);
        t0 = cyc + 1;
        for (int p = 0; p < 300; p++) begin
            push(EV_RISE, t0 + 7 + 16 * p);
            push(EV_FALL, t0 + 10 + 16 * p);
        end
        push(EV_RISE, t0 + 7 + 16 * 300);
        count(4805, -1);
        repeat (20) @(posedge clk);
        #1;
        check("t6_freeze_pulse", pulse_out, 1);
        check("t6_freeze_busy", busy, 1);
        check("t6_freeze_drain", exp_q.size(), 0);
        t1 = cyc + 1;
        push(EV_FALL, t1 + 5);
        count(3, -1);
        sb_drain("t6_resume_drain");
        check("t6_busy_run", busy, 1);
        pulse_stop();
        check("t6_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
